// File: rtl/produto_pkg.sv
// Shared constants, FSM state type and width helper for the product accumulator.
// Optional rounded-mean output is selected by PRODUTO_ACUMULADOR_MEDIA_EN.
package produto_pkg;

    localparam int P_W = 19;
    localparam int A_W = 10;
    localparam int B_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Log2 growth keeps N_ACC full-scale products from wrapping.
    function automatic int acc_width(input int p_w, input int n_acc);
        return p_w + $clog2(n_acc);
    endfunction

endpackage

// File: rtl/produto_media.sv
// Round-half-up divide by 2**SH; SH == 0 degenerates to a plain wire.
// The top sets SH from PRODUTO_ACUMULADOR_MEDIA_EN.
module produto_media #(
    parameter int ACC_W = 22,
    parameter int SH    = 3
) (
    input  logic [ACC_W-1:0] total_i,
    output logic [ACC_W-1:0] mean_o
);

    generate
        if (SH == 0) begin : g_raw
            assign mean_o = total_i;
        end else begin : g_round
            localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (SH - 1);
            logic [ACC_W-1:0] biased;
            // Cannot wrap: N_ACC*(2**P_W-1) + N_ACC/2 < 2**ACC_W.
            assign biased = total_i + HALF;
            assign mean_o = biased >> SH;
        end
    endgenerate

endmodule

// File: rtl/produto_acumulador.sv
// Sums N_ACC accepted multiplier products and offers the total on a valid/ready port.
// Define PRODUTO_ACUMULADOR_MEDIA_EN to output the rounded mean instead of the raw total.
module produto_acumulador
    import produto_pkg::state_t;
    import produto_pkg::IDLE;
    import produto_pkg::ACCUM;
    import produto_pkg::HOLD;
    import produto_pkg::acc_width;
#(
    parameter int P_W   = produto_pkg::P_W,
    parameter int N_ACC = 8,
    parameter int ACC_W = acc_width(P_W, N_ACC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P_W-1:0]   p_in,
    input  logic             p_valid,
    input  logic             clr,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             drop,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_ACC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);
`ifdef PRODUTO_ACUMULADOR_MEDIA_EN
    localparam int MEAN_SH = $clog2(N_ACC);
`else
    localparam int MEAN_SH = 0;
`endif

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] sum_q;
    logic             sum_valid_q;
    logic             drop_q;
    logic             busy_q;

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] total;
    logic [ACC_W-1:0] result;

    assign p_ext = ACC_W'(p_in);
    assign total = acc_q + p_ext;

    produto_media #(
        .ACC_W (ACC_W),
        .SH    (MEAN_SH)
    ) u_media (
        .total_i (total),
        .mean_o  (result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        drop_q <= 1'b0;
                    end else if (p_valid) begin
                        acc_q   <= p_ext;
                        cnt_q   <= CNT_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (clr) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        drop_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (p_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            sum_q       <= result;
                            sum_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            state_q     <= HOLD;
                        end else begin
                            acc_q <= total;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // The multiplier cannot stall, so an unconsumed result forces a drop.
                    if (clr) begin
                        drop_q <= 1'b0;
                    end else if (p_valid && !sum_ready) begin
                        drop_q <= 1'b1;
                    end
                    if (sum_ready) begin
                        sum_valid_q <= 1'b0;
                        if (p_valid) begin
                            acc_q   <= p_ext;
                            cnt_q   <= CNT_W'(1);
                            busy_q  <= 1'b1;
                            state_q <= ACCUM;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = sum_valid_q;
    assign drop      = drop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_produto_acumulador.sv
// Self-checking bench for produto_acumulador: vector table, corner sequences, random run vs model.
// Expectations follow PRODUTO_ACUMULADOR_MEDIA_EN when it is defined.
module tb_produto_acumulador;

    localparam int N     = 8;
    localparam int P_W   = 19;
    localparam int ACC_W = 22;

    logic             clk;
    logic             rst;
    logic [P_W-1:0]   p_in;
    logic             p_valid;
    logic             clr;
    logic [ACC_W-1:0] sum_out;
    logic             sum_valid;
    logic             sum_ready;
    logic             drop;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer = 0;

    // Reference model state: samples of the running sum, pending result, last output.
    int     q[$];
    bit     pend;
    longint last_out;
    bit     mdrop;

    produto_acumulador #(
        .P_W   (P_W),
        .N_ACC (N),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .clr       (clr),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .drop      (drop),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint mean(input longint t);
`ifdef PRODUTO_ACUMULADOR_MEDIA_EN
        return (t + N / 2) / N;
`else
        return t;
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        longint t;
        if (rst) begin
            q.delete();
            pend     = 1'b0;
            last_out = 0;
            mdrop    = 1'b0;
        end else if (pend) begin
            if (clr) mdrop = 1'b0;
            else if (p_valid && !sum_ready) mdrop = 1'b1;
            if (sum_ready) begin
                pend = 1'b0;
                n_xfer++;
                $display("xfer %0d: sum_out=%0d", n_xfer, last_out);
                if (p_valid) q.push_back(int'(p_in));
            end
        end else if (clr) begin
            q.delete();
            mdrop = 1'b0;
        end else if (p_valid) begin
            q.push_back(int'(p_in));
            if (q.size() == N) begin
                t = 0;
                foreach (q[i]) t += q[i];
                last_out = mean(t);
                pend     = 1'b1;
                q.delete();
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after it.
    task automatic cyc(input logic r, input logic pv, input int pin, input logic c, input logic rdy);
        rst       = r;
        p_valid   = pv;
        p_in      = P_W'(pin);
        clr       = c;
        sum_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        chk("sum_valid", longint'(sum_valid), longint'(pend));
        chk("sum_out", longint'(sum_out), last_out);
        chk("drop", longint'(drop), longint'(mdrop));
        chk("busy", longint'(busy), longint'(q.size() != 0));
    endtask

    typedef struct {
        int     base;
        int     step;
        longint exp_total;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int gap;
        vecs[0] = '{base: 522753, step: 0, exp_total: 64'd4182024};
        vecs[1] = '{base: 1,      step: 1, exp_total: 64'd36};
        vecs[2] = '{base: 100,    step: 0, exp_total: 64'd800};
        vecs[3] = '{base: 0,      step: 0, exp_total: 64'd0};
        vecs[4] = '{base: 524287, step: 0, exp_total: 64'd4194296};

        rst = 1'b1; p_valid = 1'b0; p_in = '0; clr = 1'b0; sum_ready = 1'b0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 5, 0, 1);
        chk("rst_sum_out", longint'(sum_out), 0);
        chk("rst_valid", longint'(sum_valid), 0);

        // Vector table: 8 back-to-back samples each, then handshake.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++) begin
                cyc(0, 1, vecs[v].base + i * vecs[v].step, 0, 1);
                if (i < N - 1) chk("tbl_busy", longint'(busy), 1);
            end
            chk("tbl_valid", longint'(sum_valid), 1);
            chk("tbl_sum", longint'(sum_out), mean(vecs[v].exp_total));
            chk("tbl_drop", longint'(drop), 0);
            cyc(0, 0, 0, 0, 1);
            chk("tbl_consumed", longint'(sum_valid), 0);
        end

        // Backpressure: result held, extra samples dropped, then handshake+restart.
        for (int i = 1; i <= N; i++) cyc(0, 1, i, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 99, 0, 0);
            chk("bp_hold_valid", longint'(sum_valid), 1);
            chk("bp_hold_sum", longint'(sum_out), mean(36));
        end
        chk("bp_drop", longint'(drop), 1);
        cyc(0, 1, 10, 0, 1);
        chk("bp_hs_valid", longint'(sum_valid), 0);
        chk("bp_hs_busy", longint'(busy), 1);
        chk("bp_drop_kept", longint'(drop), 1);
        for (int i = 0; i < N - 1; i++) cyc(0, 1, 0, 0, 0);
        chk("bp_restart_sum", longint'(sum_out), mean(10));
        cyc(0, 0, 0, 0, 1);

        // Gapped input: busy stays high across idle gaps.
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) begin
                    cyc(0, 0, 0, 0, 0);
                    chk("gap_busy", longint'(busy), 1);
                end
            end
            cyc(0, 1, 100, 0, 0);
        end
        chk("gap_valid", longint'(sum_valid), 1);
        chk("gap_sum", longint'(sum_out), mean(800));
        chk("gap_busy_end", longint'(busy), 0);
        cyc(0, 0, 0, 0, 1);

        // clr mid-run discards partial sum and the simultaneous sample.
        for (int i = 0; i < 5; i++) cyc(0, 1, 7, 0, 0);
        cyc(0, 1, 7, 1, 0);
        chk("clr_busy", longint'(busy), 0);
        chk("clr_drop", longint'(drop), 0);
        for (int i = 0; i < N; i++) cyc(0, 1, 1, 0, 0);
        chk("clr_sum", longint'(sum_out), mean(8));
        cyc(0, 0, 0, 0, 1);

        // Reset while a result is pending.
        for (int i = 0; i < N; i++) cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 3, 0, 0);
        chk("hold_valid", longint'(sum_valid), 1);
        cyc(1, 1, 3, 0, 0);
        chk("rsthold_valid", longint'(sum_valid), 0);
        chk("rsthold_sum", longint'(sum_out), 0);
        chk("rsthold_drop", longint'(drop), 0);
        chk("rsthold_busy", longint'(busy), 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cyc(logic'($urandom_range(0, 399) == 0),
                logic'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0) ? 524287 : int'($urandom_range(0, 524287)),
                logic'($urandom_range(0, 59) == 0),
                logic'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/produto_acumulador.md
Name: produto_acumulador

Overview:
- Stage directly downstream of the registered 10x9 unsigned multiplier; consumes its 19-bit product each cycle a valid flag accompanies it.
- Sums N_ACC consecutive accepted products into a widened unsigned accumulator and presents the total on a valid/ready output port.
- Used for CORDIC timing tests and gain averaging.
- The multiplier cannot be stalled, so this block flags any product arriving while its result is still unconsumed.

Parameters:
- P_W, 19, product input width; matches the multiplier output.
- N_ACC, 8, number of products per sum. Power of two, 2..256.
- ACC_W, P_W+$clog2(N_ACC) (22), accumulator and output width. Sized so no overflow is possible.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- p_in  in  P_W  unsigned product from multiplier p_out
- p_valid  in  1  p_in valid this cycle
- clr  in  1  synchronous abort of the current accumulation
- sum_out  out  ACC_W  accumulated result
- sum_valid  out  1  sum_out valid
- sum_ready  in  1  consumer accepts sum_out
- drop  out  1  sticky: a product was discarded
- busy  out  1  accumulation in progress

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high, on rst sampled at posedge clk.
  - On reset: state=IDLE; acc=0; cnt=0; sum_out=0; sum_valid=0; drop=0; busy=0.
  - rst overrides every other input, including mid-accumulation and mid-HOLD. A pending result is lost.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - On p_valid: acc<=p_in, cnt<=1, go to ACCUM, busy=1.
  - If N_ACC==1 is ever allowed, go straight to HOLD. The constraint N_ACC>=2 makes this path unused.
- ACCUM:
  - On p_valid: acc<=acc+p_in, cnt<=cnt+1.
  - When the accepted sample is the N_ACC-th (cnt==N_ACC-1 before the edge):
    - sum_out<=acc+p_in, sum_valid<=1, go to HOLD, busy<=0.
    - acc and cnt return to 0.
  - Latency: sum_valid rises on the cycle after the last sample is accepted.
- HOLD:
  - sum_out and sum_valid stay stable until sum_valid&&sum_ready at a clock edge.
  - On handshake: sum_valid<=0.
  - If p_valid is high in the same cycle as the handshake, the sample starts a new accumulation (acc<=p_in, cnt<=1, ACCUM). It is not dropped.
  - If p_valid is high with no handshake: the sample is discarded and drop<=1.
- drop: sticky; cleared only by rst or clr.
- clr:
  - In IDLE/ACCUM: acc<=0, cnt<=0, go to IDLE, drop<=0. A simultaneous p_valid sample is ignored, not counted as dropped.
  - In HOLD: only drop is cleared; the pending result is kept.
- Arithmetic: unsigned throughout. Adder width ACC_W. Wrap-around is impossible by construction; max sum = N_ACC*(2^P_W-1).
- sum_ready is ignored outside HOLD.

Optional Feature:
- Macro PRODUTO_ACUMULADOR_MEDIA_EN.
- Defined: on the transition to HOLD, sum_out <= (total + N_ACC/2) >> log2(N_ACC). This is the rounded mean, round-half-up, zero-extended to ACC_W. All timing is unchanged.
- Undefined: sum_out is the raw total. No rounding logic is synthesized.

Decomposition:
- Package produto_pkg:
  - P_W=19, A_W=10, B_W=9 constants.
  - State enum (IDLE, ACCUM, HOLD).
  - Width helper for ACC_W.
- One natural sub-module, produto_media: combinational round-and-shift used only under PRODUTO_ACUMULADOR_MEDIA_EN. Everything else stays in the top.

Test Plan:
- Full scale: 8 consecutive p_valid with p_in=522753 (1023*511) and sum_ready=1 -> sum_valid one cycle after the 8th sample, sum_out=4182024, drop=0. With MEDIA_EN -> 522753.
- Rounding: p_in=1..8 on consecutive cycles -> sum_out=36. With MEDIA_EN -> 5 (4.5 rounded up).
- Backpressure: complete a sum with sum_ready=0, then 3 more p_valid -> sum_out/sum_valid held stable, drop=1. Then raise sum_ready together with p_valid (p_in=10) -> handshake, new ACCUM with acc=10, cnt=1, drop remains 1.
- Gapped input: 8 samples of value 100 with p_valid idle gaps of 0-3 random cycles -> sum_out=800; busy high from the first sample to the last.
- clr mid-run: 5 samples of 7, then clr with p_valid=1 -> IDLE, busy=0. The next 8 samples of 1 give sum_out=8.
- Reset mid-HOLD: rst asserted while sum_valid=1 -> next cycle sum_valid=0, sum_out=0, drop=0, state IDLE.
